// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter fed by a small synchronous FIFO. Words are
//                accepted on a valid/ready handshake, queued, and sent as
//                LSB-first frames (start, data, optional parity, stop).
//                While words remain queued, frames follow each other with
//                no idle cycles between them.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH   : data bits per frame (5..9)
//    CLKS_PER_BIT : clk cycles per serial bit (>= 2)
//    STOP_BITS    : stop bits per frame (1 or 2)
//    FIFO_DEPTH   : queued words, power of 2, >= 2
//    PARITY_ODD   : 0 = even parity, 1 = odd parity (parity builds only)
//  Build option
//    UART_TX_PARITY_EN : when defined, each frame carries one parity bit
//                        between the data bits and the stop bit(s)
//  Ports
//    clk        in   clock, rising edge
//    rst        in   asynchronous reset, active low
//    wr_data    in   word to transmit
//    wr_valid   in   wr_data valid this cycle
//    wr_ready   out  FIFO can accept a word (registered, equals !full)
//    tx         out  serial line, idle high (registered)
//    busy       out  frame in progress (registered)
//    fifo_count out  queued words, excluding the word being sent
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = 4;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);

    // Reject unsupported configurations at elaboration time.
    generate
        if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (CLKS_PER_BIT < 2) ||
            ((STOP_BITS != 1) && (STOP_BITS != 2)) || (FIFO_DEPTH < 2) ||
            ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
            ((PARITY_ODD != 0) && (PARITY_ODD != 1))) begin : g_bad_params
            $error("uart_tx_fifo: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_wr_ready;

    // ------------------------------------------------------------------
    // Transmit state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_BIT_W-1:0]    r_bit;      // data-bit index in DATA, stop-bit index in STOP
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  r_busy;
`ifdef UART_TX_PARITY_EN
    localparam logic       c_PAR_ODD = (PARITY_ODD != 0);
    logic                  r_parity;
`endif

    logic                  w_push;
    logic                  w_pop;
    logic                  w_have_data;
    logic                  w_baud_end;
    logic                  w_stop_done;
    logic [DATA_WIDTH-1:0] w_head;
    logic [c_CNT_W-1:0]    w_count_next;

    assign w_push      = wr_valid && r_wr_ready;
    assign w_have_data = (r_count != '0);
    assign w_baud_end  = (r_baud == c_BAUD_LAST);
    assign w_stop_done = (r_state == S_STOP) && w_baud_end && (r_bit == c_STOP_LAST);
    // The head word leaves the FIFO when a new frame starts, either from
    // idle or straight out of the final stop bit of the previous frame.
    assign w_pop       = w_have_data && ((r_state == S_IDLE) || w_stop_done);
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count    <= w_count_next;
            // Registered from the next count so ready tracks !full exactly.
            r_wr_ready <= (w_count_next != c_CNT_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer. tx is produced from the next state so that the
    // line changes on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state  <= S_START;
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_shift  <= w_head;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^w_head) ^ c_PAR_ODD;
`endif
                    end
                end

                S_START: begin
                    if (w_baud_end) begin
                        r_state <= S_DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == c_DATA_LAST) begin
                            r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + c_BIT_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_state <= S_STOP;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == c_STOP_LAST) begin
                            r_bit <= '0;
                            if (w_have_data) begin
                                // Chain the next frame with no idle gap.
                                r_state  <= S_START;
                                r_shift  <= w_head;
                                r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                                r_parity <= (^w_head) ^ c_PAR_ODD;
`endif
                            end else begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + c_BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready   = r_wr_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo. Two
//                instances with CLKS_PER_BIT=4: u_dut_a (1 stop bit, even
//                parity sense) and u_dut_b (2 stop bits, odd parity sense).
//                tx/busy/wr_ready are logged every falling edge into history
//                arrays; frames are then compared as cycle-by-cycle waveforms
//                against hand-built expected frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB  = 4;
    localparam int HIST = 4096;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int LEN_A = (1 + 8 + PAR_EN + 1) * CPB;
    localparam int LEN_B = (1 + 8 + PAR_EN + 2) * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data_a, wr_data_b;
    logic       wr_valid_a, wr_valid_b;
    logic       wr_ready_a, wr_ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic [2:0] count_a, count_b;

    int n_run;
    int n_fail;
    int cyc;

    logic h_tx_a [HIST];
    logic h_busy_a [HIST];
    logic h_rdy_a [HIST];
    logic h_tx_b [HIST];
    logic h_busy_b [HIST];

    uart_tx_fifo #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
        .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .wr_data(wr_data_a), .wr_valid(wr_valid_a),
        .wr_ready(wr_ready_a), .tx(tx_a), .busy(busy_a), .fifo_count(count_a)
    );

    uart_tx_fifo #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
        .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .wr_data(wr_data_b), .wr_valid(wr_valid_b),
        .wr_ready(wr_ready_b), .tx(tx_b), .busy(busy_b), .fifo_count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HIST) begin
            h_tx_a[cyc]   <= tx_a;
            h_busy_a[cyc] <= busy_a;
            h_rdy_a[cyc]  <= wr_ready_a;
            h_tx_b[cyc]   <= tx_b;
            h_busy_b[cyc] <= busy_b;
        end
    end

    // Expected tx waveform, one bit per clk cycle, bit 0 = first start-bit cycle.
    function automatic logic [63:0] exp_wave(input logic [7:0] d, input int stops, input bit odd);
        logic [15:0] slots;
        logic [63:0] w;
        int          nslots;
        slots    = 16'hFFFF;
        slots[0] = 1'b0;
        for (int i = 0; i < 8; i++) slots[1+i] = d[i];
        nslots = 9;
        if (PAR_EN != 0) begin
            slots[9] = (^d) ^ odd;
            nslots   = 10;
        end
        nslots = nslots + stops;
        w = '0;
        for (int j = 0; j < 64; j++) if ((j / CPB) < nslots) w[j] = slots[j/CPB];
        return w;
    endfunction

    function automatic logic [63:0] obs_wave(input int which, input int s, input int len);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < len; j++) begin
            if ((s + j) < HIST) w[j] = (which == 0) ? h_tx_a[s+j] : h_tx_b[s+j];
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    task test_reset;
        int s1;
        int bad;
        #2;
        n_run++; if (tx_a !== 1'b1)       begin n_fail++; $display("FAIL por_tx: got %b want 1", tx_a); end
        n_run++; if (busy_a !== 1'b0)     begin n_fail++; $display("FAIL por_busy: got %b want 0", busy_a); end
        n_run++; if (count_a !== 3'd0)    begin n_fail++; $display("FAIL por_count: got %0d want 0", count_a); end
        n_run++; if (wr_ready_a !== 1'b1) begin n_fail++; $display("FAIL por_ready: got %b want 1", wr_ready_a); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_run++; if ({tx_a, busy_a, wr_ready_a, tx_b} !== 4'b1011)
            begin n_fail++; $display("FAIL post_rst_idle: got %b want 1011", {tx_a, busy_a, wr_ready_a, tx_b}); end

        // Mid-frame asynchronous reset, data 0x00 keeps tx low in DATA.
        wr_data_a = 8'h00; wr_valid_a = 1'b1;
        @(negedge clk); wr_valid_a = 1'b0;
        repeat (10) @(negedge clk);
        n_run++; if ({tx_a, busy_a} !== 2'b01)
            begin n_fail++; $display("FAIL midframe_pre: tx,busy got %b want 01", {tx_a, busy_a}); end
        #2 rst = 1'b0;
        #1;
        n_run++; if (tx_a !== 1'b1)       begin n_fail++; $display("FAIL midframe_rst_tx: got %b want 1", tx_a); end
        n_run++; if (busy_a !== 1'b0)     begin n_fail++; $display("FAIL midframe_rst_busy: got %b want 0", busy_a); end
        n_run++; if (count_a !== 3'd0)    begin n_fail++; $display("FAIL midframe_rst_count: got %0d want 0", count_a); end
        n_run++; if (wr_ready_a !== 1'b1) begin n_fail++; $display("FAIL midframe_rst_ready: got %b want 1", wr_ready_a); end
        @(negedge clk); rst = 1'b1;
        s1 = cyc;
        repeat (60) @(negedge clk);
        bad = 0;
        for (int j = 0; j < 55; j++) if (h_tx_a[s1+j] !== 1'b1 || h_busy_a[s1+j] !== 1'b0) bad++;
        n_run++; if (bad != 0) begin n_fail++; $display("FAIL midframe_idle_after: %0d bad cycles, want 0", bad); end
    endtask

    // ------------------------------------------------------------------
    task test_single;
        int s0;
        int bad;
        logic [63:0] o, e;
        @(negedge clk); wr_data_a = 8'hA5; wr_valid_a = 1'b1;
        @(negedge clk); wr_valid_a = 1'b0;
        n_run++; if ({count_a, tx_a, busy_a} !== {3'd1, 2'b10})
            begin n_fail++; $display("FAIL single_accept: count,tx,busy got %0d,%b,%b want 1,1,0", count_a, tx_a, busy_a); end
        @(negedge clk); s0 = cyc;
        n_run++; if ({count_a, tx_a, busy_a} !== {3'd0, 2'b01})
            begin n_fail++; $display("FAIL single_latency: count,tx,busy got %0d,%b,%b want 0,0,1", count_a, tx_a, busy_a); end
        repeat (LEN_A + 4) @(negedge clk);
        o = obs_wave(0, s0, LEN_A);
        e = exp_wave(8'hA5, 1, 1'b0);
        n_run++; if (o !== e) begin n_fail++; $display("FAIL single_frame_A5: got %h want %h", o, e); end
        bad = 0;
        for (int j = 0; j < LEN_A; j++) if (h_busy_a[s0+j] !== 1'b1) bad++;
        if (h_busy_a[s0-1] !== 1'b0) bad++;
        if (h_busy_a[s0+LEN_A] !== 1'b0) bad++;
        n_run++; if (bad != 0) begin n_fail++; $display("FAIL single_busy_len: %0d bad cycles, want %0d-cycle pulse", bad, LEN_A); end
        n_run++; if (h_tx_a[s0+LEN_A] !== 1'b1) begin n_fail++; $display("FAIL single_idle_after: got %b want 1", h_tx_a[s0+LEN_A]); end
    endtask

    // ------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
    task test_parity;
        int s0;
        logic [63:0] o, e;
        @(negedge clk); wr_data_a = 8'h07; wr_valid_a = 1'b1; wr_data_b = 8'h07; wr_valid_b = 1'b1;
        @(negedge clk); wr_valid_a = 1'b0; wr_valid_b = 1'b0;
        @(negedge clk); s0 = cyc;
        repeat (LEN_B + 4) @(negedge clk);
        n_run++; if (h_tx_a[s0+9*CPB+1] !== 1'b1) begin n_fail++; $display("FAIL parity_even_07: got %b want 1", h_tx_a[s0+9*CPB+1]); end
        n_run++; if (h_tx_b[s0+9*CPB+1] !== 1'b0) begin n_fail++; $display("FAIL parity_odd_07: got %b want 0", h_tx_b[s0+9*CPB+1]); end
        o = obs_wave(0, s0, LEN_A); e = exp_wave(8'h07, 1, 1'b0);
        n_run++; if (o !== e) begin n_fail++; $display("FAIL parity_frame_a: got %h want %h", o, e); end
        o = obs_wave(1, s0, LEN_B); e = exp_wave(8'h07, 2, 1'b1);
        n_run++; if (o !== e) begin n_fail++; $display("FAIL parity_frame_b: got %h want %h", o, e); end
        n_run++; if (h_busy_a[s0+43] !== 1'b1 || h_busy_a[s0+44] !== 1'b0)
            begin n_fail++; $display("FAIL parity_len44: busy@43,44 got %b%b want 10", h_busy_a[s0+43], h_busy_a[s0+44]); end
    endtask
`endif

    // ------------------------------------------------------------------
    task test_fifo_full;
        int s0;
        int bad;
        logic [63:0] o, e;
        @(negedge clk); wr_data_a = 8'h01; wr_valid_a = 1'b1;
        @(negedge clk); wr_data_a = 8'h02;
        @(negedge clk); s0 = cyc; wr_data_a = 8'h03;
        @(negedge clk); wr_data_a = 8'h04;
        @(negedge clk); wr_data_a = 8'h05;
        @(negedge clk);
        n_run++; if ({wr_ready_a, count_a} !== {1'b0, 3'd4})
            begin n_fail++; $display("FAIL full_state: ready,count got %b,%0d want 0,4", wr_ready_a, count_a); end
        wr_data_a = 8'h06;
        @(negedge clk); wr_valid_a = 1'b0;
        n_run++; if ({wr_ready_a, count_a} !== {1'b0, 3'd4})
            begin n_fail++; $display("FAIL full_drop: ready,count got %b,%0d want 0,4", wr_ready_a, count_a); end
        repeat (5 * LEN_A + 12) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            o = obs_wave(0, s0 + f * LEN_A, LEN_A);
            e = exp_wave(8'(f + 1), 1, 1'b0);
            n_run++; if (o !== e) begin n_fail++; $display("FAIL b2b_frame%0d: got %h want %h", f + 1, o, e); end
        end
        bad = 0;
        for (int j = 0; j < 5 * LEN_A; j++) if (h_busy_a[s0+j] !== 1'b1) bad++;
        n_run++; if (bad != 0) begin n_fail++; $display("FAIL b2b_busy_gap: %0d cycles low, want 0", bad); end
        bad = 0;
        for (int j = 0; j < 8; j++) if (h_tx_a[s0+5*LEN_A+j] !== 1'b1 || h_busy_a[s0+5*LEN_A+j] !== 1'b0) bad++;
        n_run++; if (bad != 0) begin n_fail++; $display("FAIL b2b_no_sixth: %0d bad cycles, want 0", bad); end
        n_run++; if ({h_rdy_a[s0+LEN_A-1], h_rdy_a[s0+LEN_A]} !== 2'b01)
            begin n_fail++; $display("FAIL ready_on_pop: got %b%b want 01", h_rdy_a[s0+LEN_A-1], h_rdy_a[s0+LEN_A]); end
    endtask

    // ------------------------------------------------------------------
    task test_stop2;
        int s0;
        int bad;
        logic [63:0] o, e;
        @(negedge clk); wr_data_b = 8'hFF; wr_valid_b = 1'b1;
        @(negedge clk); wr_data_b = 8'h3C;
        @(negedge clk); s0 = cyc; wr_valid_b = 1'b0;
        repeat (2 * LEN_B + 8) @(negedge clk);
        o = obs_wave(1, s0, LEN_B); e = exp_wave(8'hFF, 2, 1'b1);
        n_run++; if (o !== e) begin n_fail++; $display("FAIL stop2_frame_FF: got %h want %h", o, e); end
        o = obs_wave(1, s0 + LEN_B, LEN_B); e = exp_wave(8'h3C, 2, 1'b1);
        n_run++; if (o !== e) begin n_fail++; $display("FAIL stop2_frame_3C: got %h want %h", o, e); end
        bad = 0;
        for (int j = LEN_B - 8; j < LEN_B; j++) if (h_tx_b[s0+j] !== 1'b1) bad++;
        if (h_tx_b[s0+LEN_B] !== 1'b0) bad++;
        n_run++; if (bad != 0) begin n_fail++; $display("FAIL stop2_hold8_then_start: %0d bad cycles, want 0", bad); end
        n_run++; if (h_busy_b[s0+2*LEN_B] !== 1'b0 || h_busy_b[s0+2*LEN_B-1] !== 1'b1)
            begin n_fail++; $display("FAIL stop2_busy_end: got %b%b want 10", h_busy_b[s0+2*LEN_B-1], h_busy_b[s0+2*LEN_B]); end
    endtask

    // ------------------------------------------------------------------
    task test_reset_midop;
        int s0;
        int s1;
        int bad;
        @(negedge clk); wr_data_a = 8'h11; wr_valid_a = 1'b1;
        @(negedge clk); wr_data_a = 8'h22;
        @(negedge clk); s0 = cyc; wr_data_a = 8'h33;
        @(negedge clk); wr_valid_a = 1'b0;
        // Slot 3 of the second frame is data bit 2 of 0x22, a zero.
        while (cyc < s0 + LEN_A + 3 * CPB + 1) @(negedge clk);
        n_run++; if ({tx_a, busy_a, count_a} !== {2'b01, 3'd1})
            begin n_fail++; $display("FAIL midop_pre: tx,busy,count got %b,%b,%0d want 0,1,1", tx_a, busy_a, count_a); end
        #2 rst = 1'b0;
        #1;
        n_run++; if ({tx_a, busy_a, wr_ready_a, count_a} !== {3'b101, 3'd0})
            begin n_fail++; $display("FAIL midop_rst: tx,busy,ready,count got %b,%b,%b,%0d want 1,0,1,0", tx_a, busy_a, wr_ready_a, count_a); end
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        s1 = cyc;
        repeat (150) @(negedge clk);
        bad = 0;
        for (int j = 0; j < 145; j++) if (h_tx_a[s1+j] !== 1'b1 || h_busy_a[s1+j] !== 1'b0) bad++;
        n_run++; if (bad != 0) begin n_fail++; $display("FAIL midop_no_resume: %0d bad cycles, want 0", bad); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_run      = 0;
        n_fail     = 0;
        cyc        = 0;
        rst        = 1'b1;
        wr_data_a  = 8'h00; wr_valid_a = 1'b0;
        wr_data_b  = 8'h00; wr_valid_b = 1'b0;
        #1 rst = 1'b0;
        test_reset;
        test_single;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_fifo_full;
        test_stop2;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
